clear_engine: RTL and testbench

Hardware screen-clear responder for the text display. It accepts the clear request (`clear_start`, `mode`) and the packed colour word produced by the I/O command decoder. It then walks the character framebuffer, writing blank cells in the current colours, either the whole screen or a single row. The block sits between the I/O command decoder and the video-RAM write arbiter, and it holds the clear while `busy` is high.

---
 rtl/clear_engine_if.sv | 29 ++
 rtl/clear_engine.sv | 111 +++++++++++
 tb/tb_clear_engine.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/clear_engine_if.sv
// Clear-engine bus: clear request from the command decoder plus the framebuffer
// write port toward the video-RAM arbiter. Write handshake: a cell is transferred on a rising edge where wr_en & wr_ready; wr_addr/wr_data hold until then.
interface clear_engine_if #(
  parameter int ADDR_W = 12,
  parameter int ROW_W  = 5
);
  logic              clear_start;
  logic              mode;
  logic [ROW_W-1:0]  line_row;
  logic [15:0]       color_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              wr_ready;
  logic              busy;
  logic              done;

  // Request/arbiter side.
  modport master (
    output clear_start, mode, line_row, color_data, wr_ready,
    input  wr_en, wr_addr, wr_data, busy, done
  );

  // Clear engine side.
  modport slave (
    input  clear_start, mode, line_row, color_data, wr_ready,
    output wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/clear_engine.sv
// Screen/line clear engine: on a rising clear_start edge seen in IDLE, writes blank
// cells in the latched colours over the whole framebuffer or one row, then pulses done.
module clear_engine #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 30,
  parameter logic [7:0]  FILL_CHAR = 8'h20,
  parameter int          ADDR_W    = $clog2(COLS*ROWS),
  parameter int          ROW_W     = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                rst,
  clear_engine_if.slave       bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] L_LAST    = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] L_COLS    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] L_COLS_M1 = ADDR_W'(COLS-1);
  localparam logic [ADDR_W-1:0] L_ONE     = ADDR_W'(1);

  state_t            r_state;
  logic              r_start_q;
  logic [15:0]       r_color;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_end;
  logic              r_wr_en;
  logic              r_busy;
  logic              r_done;

  logic              w_start;
  logic              w_row_ok;
  logic [ADDR_W-1:0] w_line_base;

  assign w_start     = bus.clear_start & ~r_start_q;
  assign w_row_ok    = int'(bus.line_row) < ROWS;
  assign w_line_base = ADDR_W'(bus.line_row) * L_COLS;

  // start_q resets high so a request level held across reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b1;
      r_color   <= 16'hFF00;
      r_addr    <= '0;
      r_end     <= '0;
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_start_q <= bus.clear_start;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_color <= bus.color_data;
            r_busy  <= 1'b1;
            if (!bus.mode) begin
              r_addr  <= '0;
              r_end   <= L_LAST;
              r_wr_en <= 1'b1;
              r_state <= S_RUN;
            end else if (w_row_ok) begin
              r_addr  <= w_line_base;
              r_end   <= w_line_base + L_COLS_M1;
              r_wr_en <= 1'b1;
              r_state <= S_RUN;
            end else begin
              // Row off-screen: acknowledge the request without touching memory.
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (bus.wr_ready) begin
            if (r_addr == r_end) begin
              r_wr_en <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_addr <= r_addr + L_ONE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_wr_en <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_addr;
  assign bus.wr_data = {FILL_CHAR, r_color};
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_clear_engine.sv
// Bench for clear_engine with an 8x4 screen: table of clear jobs checked through an
// expected-write queue, plus hand sequences for reset behaviour and mid-clear abort.
module tb_clear_engine;

  localparam int COLS   = 8;
  localparam int ROWS   = 4;
  localparam int ADDR_W = 5;
  localparam int ROW_W  = 3;

  typedef struct {
    logic        mode;
    logic [2:0]  row;
    logic [15:0] color;
    int          stall_addr;
    int          stall_n;
    bit          poke;
    int          base;
    int          count;
    int          run;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  clear_engine_if #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) bus ();

  clear_engine #(
    .COLS(COLS), .ROWS(ROWS), .FILL_CHAR(8'h20), .ADDR_W(ADDR_W), .ROW_W(ROW_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [28:0] exp_q[$];
  int checks  = 0;
  int errors  = 0;
  int run_cnt = 0;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Every cycle with wr_en high must present the head of the queue; it pops on acceptance.
  always @(negedge clk) begin
    if (!rst && bus.wr_en) begin
      run_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, bus.wr_addr}, 32'hFFFF_FFFF);
      end else begin
        check("wr_cell", {3'd0, bus.wr_addr, bus.wr_data}, {3'd0, exp_q[0]});
        if (bus.wr_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic push_cells(input int base, input int count, input logic [15:0] color);
    for (int i = 0; i < count; i++)
      exp_q.push_back({5'(base + i), 8'h20, color});
  endtask

  task automatic run_case(input string name, input vec_t v);
    int   cyc, done_n, busy_n, stall_left;
    bit   seen_done;
    push_cells(v.base, v.count, v.color);
    run_cnt = 0;
    @(posedge clk); #1;
    bus.mode        = v.mode;
    bus.line_row    = v.row;
    bus.color_data  = v.color;
    bus.clear_start = 1'b1;
    stall_left = v.stall_n;
    cyc = 0; done_n = 0; busy_n = 0; seen_done = 0;
    while (!seen_done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      bus.clear_start = 1'b0;
      if (v.poke && cyc == 5) begin
        bus.color_data  = 16'h1122;
        bus.clear_start = 1'b1;
      end
      busy_n += int'(bus.busy);
      done_n += int'(bus.done);
      if (bus.done) seen_done = 1;
      if (bus.wr_en && int'(bus.wr_addr) == v.stall_addr && stall_left > 0) begin
        bus.wr_ready = 1'b0;
        stall_left--;
      end else begin
        bus.wr_ready = 1'b1;
      end
    end
    check({name, "_timeout"}, {31'd0, seen_done}, 32'd1);
    check({name, "_done_pulses"}, done_n, 32'd1);
    check({name, "_busy_cycles"}, busy_n, v.run + 1);
    check({name, "_run_cycles"}, run_cnt, v.run);
    check({name, "_queue_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check({name, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
      check({name, "_done_after"}, {31'd0, bus.done}, 32'd0);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int cyc;
    vecs[0] = '{1'b0, 3'd0, 16'h0F01, -1, 0, 1'b0, 0, 32, 32};   // screen clear
    vecs[1] = '{1'b1, 3'd2, 16'hA055, -1, 0, 1'b0, 16, 8, 8};    // line 2
    vecs[2] = '{1'b0, 3'd0, 16'h0F01, 5, 3, 1'b0, 0, 32, 35};    // stall at addr 5
    vecs[3] = '{1'b1, 3'd5, 16'h1234, -1, 0, 1'b0, 0, 0, 0};     // row off-screen
    vecs[4] = '{1'b1, 3'd0, 16'hBEEF, 0, 1, 1'b0, 0, 8, 9};      // stall first cell
    vecs[5] = '{1'b1, 3'd3, 16'h00FF, 31, 2, 1'b0, 24, 8, 10};   // stall last cell
    vecs[6] = '{1'b0, 3'd0, 16'h0F01, -1, 0, 1'b1, 0, 32, 32};   // dropped start + colour change

    rst = 1'b1;
    bus.clear_start = 1'b1;
    bus.mode        = 1'b0;
    bus.line_row    = '0;
    bus.color_data  = 16'h0000;
    bus.wr_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_wr_addr", {27'd0, bus.wr_addr}, 32'd0);
    check("rst_wr_data", {8'd0, bus.wr_data}, 32'h0020FF00);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("held_start_busy", {31'd0, bus.busy}, 32'd0);
      check("held_start_wr_data", {8'd0, bus.wr_data}, 32'h0020FF00);
    end
    bus.clear_start = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_case($sformatf("vec%0d", i), vecs[i]);

    // Abort a screen clear at address 10; cells 0..9 are the only ones written.
    push_cells(0, 10, 16'h0F01);
    bus.mode = 1'b0;
    bus.color_data = 16'h0F01;
    bus.wr_ready = 1'b1;
    @(posedge clk); #1;
    bus.clear_start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      bus.clear_start = 1'b0;
      cyc++;
    end while (!(bus.wr_en && bus.wr_addr == 5'd10) && cyc < 100);
    check("abort_reach_10", {31'd0, bus.wr_en && bus.wr_addr == 5'd10}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    check("abort_queue", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_abort_busy", {31'd0, bus.busy}, 32'd0);
    end
    run_case("restart", vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
